// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states and line levels used by the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last clock of every CLKS_PER_BIT-cycle bit while enabled.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_PARITY_EN to include the parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 tick;
  logic                 accept;

`ifdef UART_PARITY_EN
  logic parity_q;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  // Ready depends only on state and reset, never on tx_valid.
  assign tx_ready = (state_q == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d   = PAR;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PAR: begin
`ifdef UART_PARITY_EN
        if (tick) state_d = STOP;
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is registered from the next state so tx changes on the same edge as the state.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      PAR:     tx_d = parity_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != IDLE);
    end
  end

`ifdef UART_PARITY_EN
  // Even parity is captured with the byte so the PAR slot never looks at the live input.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^tx_data;
    end
  end
`endif

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one-stop-bit instance plus a two-stop-bit instance, CLKS_PER_BIT=4.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME1 = CPB * (1 + DB + P + 1);
  localparam int FRAME2 = CPB * (1 + DB + P + 2);

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       tx2;
  logic       busy2;

  int passed = 0;
  int total  = 0;

`ifdef UART_PARITY_EN
  logic a5_seq[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam int A5_BUSY = 44;
`else
  logic a5_seq[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam int A5_BUSY = 40;
`endif

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2)) dut_stop2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level in frame slot `slot` (0 = start bit).
  function automatic logic exp_bit(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= DB) return d[slot-1];
`ifdef UART_PARITY_EN
    if (slot == DB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Called right after the accept edge; checks every cycle of a one-stop-bit frame.
  task automatic watch_frame(input logic [7:0] d, input string name, input bit hold_valid,
                             input int change_k, input logic [7:0] new_d);
    logic e;
    for (int k = 0; k < FRAME1; k++) begin
      if (k > 0) step();
      if (k == 0 && !hold_valid) tx_valid = 1'b0;
      if (k == change_k) tx_data = new_d;
      e = exp_bit(d, k / CPB);
      total++;
      if ({tx, busy, tx_ready} !== {e, 2'b10})
        $display("FAIL %s cycle %0d: tx/busy/ready=%b expected %b", name, k, {tx, busy, tx_ready}, {e, 2'b10});
      else passed++;
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if ({tx, busy, tx_ready} !== 3'b101)
      $display("FAIL %s: tx/busy/ready=%b expected 101", name, {tx, busy, tx_ready});
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_valid2 = 1'b0; tx_data2 = 8'h00;
    repeat (3) step();
    total++;
    if ({tx, busy, tx_ready, tx2, busy2, tx_ready2} !== 6'b100100)
      $display("FAIL reset_state: got %b expected 100100", {tx, busy, tx_ready, tx2, busy2, tx_ready2});
    else passed++;
    rst = 1'b0;
    #1;
    check_idle("reset_release_ready");
  endtask

  task automatic test_idle_line();
    for (int k = 0; k < 10; k++) begin
      step();
      check_idle("idle_line");
    end
  endtask

  task automatic test_frame_a5();
    int busy_cycles = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME1; k++) begin
      if (k > 0) step();
      if (busy) busy_cycles++;
      total++;
      if ({tx, tx_ready} !== {a5_seq[k / CPB], 1'b0})
        $display("FAIL frame_a5 cycle %0d: tx/ready=%b expected %b", k, {tx, tx_ready}, {a5_seq[k / CPB], 1'b0});
      else passed++;
    end
    total++;
    if (busy_cycles !== A5_BUSY)
      $display("FAIL frame_a5_busy_len: %0d cycles expected %0d", busy_cycles, A5_BUSY);
    else passed++;
    step();
    check_idle("frame_a5_end");
  endtask

  task automatic test_parity();
    tx_data = 8'h07; tx_valid = 1'b1;
    step();
    watch_frame(8'h07, "frame_07", 1'b0, -1, 8'h00);
    step();
    check_idle("frame_07_end");
  endtask

  task automatic test_back_to_back();
    tx_data = 8'h00; tx_valid = 1'b1;
    step();
    watch_frame(8'h00, "b2b_first", 1'b1, 5, 8'hFF);
    step();
    check_idle("b2b_gap");
    step();
    watch_frame(8'hFF, "b2b_second", 1'b0, -1, 8'h00);
    step();
    check_idle("b2b_end");
  endtask

  task automatic test_data_change();
    tx_data = 8'h12; tx_valid = 1'b1;
    step();
    watch_frame(8'h12, "data_change", 1'b0, 10, 8'hEE);
    step();
    check_idle("data_change_end");
  endtask

  task automatic test_reset_mid();
    logic e;
    tx_data = 8'h55; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      e = exp_bit(8'h55, k / CPB);
      total++;
      if ({tx, busy} !== {e, 1'b1})
        $display("FAIL reset_mid_pre cycle %0d: tx/busy=%b expected %b", k, {tx, busy}, {e, 1'b1});
      else passed++;
    end
    rst = 1'b1;
    step();
    total++;
    if ({tx, busy, tx_ready} !== 3'b100)
      $display("FAIL reset_mid_abort: tx/busy/ready=%b expected 100", {tx, busy, tx_ready});
    else passed++;
    rst = 1'b0;
    #1;
    check_idle("reset_mid_ready");
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    watch_frame(8'h3C, "after_reset_3c", 1'b0, -1, 8'h00);
    step();
    check_idle("after_reset_end");
  endtask

  task automatic test_stop2();
    logic e;
    int stop_high = 0;
    tx_data2 = 8'hA5; tx_valid2 = 1'b1;
    step();
    for (int k = 0; k < FRAME2; k++) begin
      if (k > 0) step();
      e = exp_bit(8'hA5, k / CPB);
      if (k >= CPB * (1 + DB + P) && tx2 === 1'b1) stop_high++;
      total++;
      if ({tx2, busy2, tx_ready2} !== {e, 2'b10})
        $display("FAIL stop2 cycle %0d: tx/busy/ready=%b expected %b", k, {tx2, busy2, tx_ready2}, {e, 2'b10});
      else passed++;
    end
    total++;
    if (stop_high !== 8)
      $display("FAIL stop2_len: stop high %0d cycles expected 8", stop_high);
    else passed++;
    step();
    total++;
    if ({tx2, busy2, tx_ready2} !== 3'b101)
      $display("FAIL stop2_idle: tx/busy/ready=%b expected 101", {tx2, busy2, tx_ready2});
    else passed++;
    step();
    total++;
    if ({tx2, busy2, tx_ready2} !== 3'b010)
      $display("FAIL stop2_restart: tx/busy/ready=%b expected 010", {tx2, busy2, tx_ready2});
    else passed++;
    tx_valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_line();
    test_frame_a5();
    test_parity();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    test_stop2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
